// File: rtl/adc_pkg.sv
// Shared definitions for the ADC serial receive path: FSM state codes,
// default sample width and two's-complement saturation limits.
package adc_pkg;

    localparam int DW_DEF = 21;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_ADJ   = 3'd2;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        ADJ   = ST_ADJ
    } rx_state_e;

    localparam int SAT_MAX = (2 ** (DW_DEF - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DW_DEF - 1));

endpackage

// File: rtl/adc_serial_rx_if.sv
// Sample-stream bundle between the ADC bit source, adc_serial_rx and the NLC.
// master drives serial bits and downstream ready; slave is the receiver.
interface adc_serial_rx_if #(parameter int DW = adc_pkg::DW_DEF);

    logic                 i_bit_vld;
    logic                 i_sdata;
    logic                 i_fs;
    logic                 i_dn_ready;
    logic signed [DW-1:0] o_x;
    logic                 o_srdyo;
    logic                 o_ovf;
    logic                 o_err_frame;
    logic [2:0]           o_state;

    modport master (
        output i_bit_vld, i_sdata, i_fs, i_dn_ready,
        input  o_x, o_srdyo, o_ovf, o_err_frame, o_state
    );

    modport slave (
        input  i_bit_vld, i_sdata, i_fs, i_dn_ready,
        output o_x, o_srdyo, o_ovf, o_err_frame, o_state
    );

endinterface

// File: rtl/adc_sat_sub.sv
// Signed DW-bit subtract (a - b) with saturation to the DW-bit range.
// Latency: combinational. Backpressure: none.
module adc_sat_sub #(
    parameter int DW = 21
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] y
);

    logic signed [DW:0] diff;

    assign diff = {a[DW-1], a} - {b[DW-1], b};

    // The two top bits disagree only when the true result left the DW-bit range.
    always_comb begin
        y = diff[DW-1:0];
        if (diff[DW] != diff[DW-1]) begin
            y = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/adc_serial_rx.sv
// Deserializes MSB-first ADC frames into DW-bit signed samples for the NLC; ADC_RX_OFFSET_EN adds offset/saturate.
// Latency: strobe the cycle after the last bit (one more with ADC_RX_OFFSET_EN).
// Backpressure: one-deep hold register; a newer word overwrites a pending one and pulses o_ovf.
module adc_serial_rx
    import adc_pkg::*;
#(
    parameter int                 DW     = DW_DEF,
    parameter logic signed [DW-1:0] OFFSET = '0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    adc_serial_rx_if.slave bus
);

    localparam int CW = $clog2(DW + 1);

    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [DW-1:0]        shreg;
    logic signed [DW-1:0] hold;
    logic                 pending;
    logic signed [DW-1:0] x_q;
    logic                 srdy_q;
    logic                 ovf_q;
    logic                 err_q;

    logic signed [DW-1:0] word_nxt;
    logic                 done;

`ifdef ADC_RX_OFFSET_EN
    adc_sat_sub #(.DW(DW)) u_sat (
        .a ($signed(shreg)),
        .b (OFFSET),
        .y (word_nxt)
    );
    assign done = (state == ADJ);
`else
    logic unused_offset;
    assign unused_offset = ^OFFSET;
    assign word_nxt = {shreg[DW-2:0], bus.i_sdata};
    assign done     = (state == SHIFT) && bus.i_bit_vld && !bus.i_fs
                      && (cnt == CW'(DW - 1));
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            hold    <= '0;
            pending <= 1'b0;
            x_q     <= '0;
            srdy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            srdy_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_bit_vld && bus.i_fs) begin
                        shreg <= {{(DW-1){1'b0}}, bus.i_sdata};
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.i_bit_vld) begin
                        if (bus.i_fs) begin
                            // Sync mid-frame: drop the partial word, this bit is a new MSB.
                            err_q <= 1'b1;
                            shreg <= {{(DW-1){1'b0}}, bus.i_sdata};
                            cnt   <= CW'(1);
                        end else begin
                            shreg <= {shreg[DW-2:0], bus.i_sdata};
                            if (cnt == CW'(DW - 1)) begin
                                cnt <= '0;
`ifdef ADC_RX_OFFSET_EN
                                state <= ADJ;
`else
                                state <= IDLE;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
`ifdef ADC_RX_OFFSET_EN
                ADJ: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase

            // A drain and a completion in the same cycle swap hold contents without overflow.
            if (done) begin
                if (pending && bus.i_dn_ready) begin
                    x_q    <= hold;
                    srdy_q <= 1'b1;
                    hold   <= word_nxt;
                end else if (pending) begin
                    hold  <= word_nxt;
                    ovf_q <= 1'b1;
                end else if (bus.i_dn_ready) begin
                    x_q    <= word_nxt;
                    srdy_q <= 1'b1;
                end else begin
                    hold    <= word_nxt;
                    pending <= 1'b1;
                end
            end else if (pending && bus.i_dn_ready) begin
                x_q     <= hold;
                srdy_q  <= 1'b1;
                pending <= 1'b0;
            end
        end
    end

    assign bus.o_x         = x_q;
    assign bus.o_srdyo     = srdy_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_err_frame = err_q;
    assign bus.o_state     = state;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: directed scenarios plus randomized frames, checked
// every cycle against a word-level model of the receiver.
module tb_adc_serial_rx;

    localparam int DW = 21;
`ifdef ADC_RX_OFFSET_EN
    localparam int OFFSET  = 100;
    localparam int MIN_GAP = 1;
`else
    localparam int OFFSET  = 0;
    localparam int MIN_GAP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_serial_rx_if #(.DW(DW)) bus ();

    adc_serial_rx #(.DW(DW), .OFFSET(DW'(OFFSET))) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Stimulus controls shared with tick()
    bit rdy     = 1'b0;
    bit rnd_rdy = 1'b0;

    // Reference model state: word-level view of the receiver
    bit in_frame;
    int nbits;
    int acc;
    bit adj_busy;
    int adj_word;
    int pend_q[$];
    int exp_x;
    bit exp_srdy, exp_ovf, exp_err;
    int exp_state;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= 2 ** (DW - 1)) ? v - 2 ** DW : v;
    endfunction

    function automatic int saturate(input int v);
        if (v > 2 ** (DW - 1) - 1) return 2 ** (DW - 1) - 1;
        if (v < -(2 ** (DW - 1))) return -(2 ** (DW - 1));
        return v;
    endfunction

    task automatic model_step(input bit r, input bit bv, input bit sd, input bit fs, input bit rd);
        bit done;
        bit had;
        int word;
        done = 1'b0;
        word = 0;
        exp_srdy = 1'b0;
        exp_ovf  = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            in_frame = 1'b0;
            nbits    = 0;
            acc      = 0;
            adj_busy = 1'b0;
            pend_q.delete();
            exp_x    = 0;
        end else begin
            if (adj_busy) begin
                // Offset-correction slot: the finished word is released, any bit is ignored
                done     = 1'b1;
                word     = saturate(adj_word - OFFSET);
                adj_busy = 1'b0;
            end else if (bv) begin
                if (fs) begin
                    if (in_frame) exp_err = 1'b1;
                    in_frame = 1'b1;
                    nbits    = 1;
                    acc      = int'(sd);
                end else if (in_frame) begin
                    acc   = acc * 2 + int'(sd);
                    nbits = nbits + 1;
                    if (nbits == DW) begin
                        in_frame = 1'b0;
`ifdef ADC_RX_OFFSET_EN
                        adj_busy = 1'b1;
                        adj_word = to_signed(acc);
`else
                        done = 1'b1;
                        word = to_signed(acc);
`endif
                    end
                end
            end
            had = (pend_q.size() > 0);
            if (rd && had) begin
                exp_x    = pend_q.pop_front();
                exp_srdy = 1'b1;
            end
            if (done) begin
                if (rd && !had) begin
                    exp_x    = word;
                    exp_srdy = 1'b1;
                end else begin
                    if (pend_q.size() > 0) begin
                        exp_ovf = 1'b1;
                        pend_q.delete();
                    end
                    pend_q.push_back(word);
                end
            end
        end
        exp_state = adj_busy ? 2 : (in_frame ? 1 : 0);
    endtask

    task automatic tick(input bit bv, input bit sd, input bit fs);
        @(negedge clk);
        if (rnd_rdy) rdy = ($urandom_range(0, 2) != 0);
        bus.i_bit_vld  = bv;
        bus.i_sdata    = sd;
        bus.i_fs       = fs;
        bus.i_dn_ready = rdy;
        @(posedge clk);
        #1;
        model_step(rst, bv, sd, fs, rdy);
        chk("srdyo", int'(bus.o_srdyo), int'(exp_srdy));
        chk("ovf", int'(bus.o_ovf), int'(exp_ovf));
        chk("err_frame", int'(bus.o_err_frame), int'(exp_err));
        chk("state", int'(bus.o_state), exp_state);
        chk("x", int'(bus.o_x), exp_x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Sends the top nb bits of v MSB-first, frame sync on the MSB
    task automatic send_bits(input int v, input int nb);
        logic [DW-1:0] w;
        w = DW'(v);
        for (int i = DW - 1; i >= DW - nb; i--) tick(1'b1, w[i], i == DW - 1);
    endtask

    task automatic send_frame(input int v);
        send_bits(v, DW);
        idle(MIN_GAP);
    endtask

    initial begin
        bus.i_bit_vld  = 1'b0;
        bus.i_sdata    = 1'b0;
        bus.i_fs       = 1'b0;
        bus.i_dn_ready = 1'b0;

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Basic frame
        rdy = 1'b1;
        send_frame(-50000);
        idle(3);

        // Backpressure: hold, drain, then a second held word drains later
        rdy = 1'b0;
        send_frame(27000);
        idle(10);
        rdy = 1'b1;
        idle(2);
        rdy = 1'b0;
        send_frame(-20000);
        idle(3);
        rdy = 1'b1;
        idle(2);

        // Overrun
        rdy = 1'b0;
        send_frame(100);
        send_frame(200);
        idle(2);
        rdy = 1'b1;
        idle(3);

        // Framing error: sync arrives on the 10th bit
        send_bits(12345, 9);
        send_frame(5);
        idle(2);

        // Saturation corners
        send_frame(-1048500);
        send_frame(1048575);
        send_frame(-1048576);
        idle(2);

        // Reset mid-frame
        send_bits(777, 12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send_frame(1);
        idle(2);

        // Drain coinciding with completion: ready rises on the last bit of the next frame
        rdy = 1'b0;
        send_frame(4242);
        send_bits(-4242, DW - 1);
        rdy = 1'b1;
        send_bits(0, 0);
        tick(1'b1, 1'b0, 1'b0);
        idle(MIN_GAP + 3);

        // Randomized frames, ready toggling, gaps, stray bits and occasional mid-frame sync
        rnd_rdy = 1'b1;
        for (int f = 0; f < 60; f++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            for (int i = DW - 1; i >= 0; i--) begin
                if ($urandom_range(0, 9) == 0) tick(1'b0, 1'($urandom), 1'b0);
                tick(1'b1, w[i], (i == DW - 1) || ($urandom_range(0, 149) == 0));
            end
            for (int g = 0; g < MIN_GAP + int'($urandom_range(0, 2)); g++)
                tick(1'($urandom), 1'($urandom), 1'b0);
        end
        rnd_rdy = 1'b0;
        rdy = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
